// File: rtl/rpxx_offset_sequencer_pkg.sv
// Shared definitions for the RPxx offset/RTC sequencer: function codes and FSM states.
package rpxx_offset_sequencer_pkg;

  localparam logic [4:0] FUN_OFFSET = 5'o06;
  localparam logic [4:0] FUN_RTC    = 5'o07;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } ofs_state_t;

  function automatic logic is_pos_fun(input logic [4:0] fun);
    return (fun == FUN_OFFSET) || (fun == FUN_RTC);
  endfunction

endpackage

// File: rtl/rpxx_settle_timer.sv
// Load/count-down/zero settle timer; shared by the RPxx positioning sequencers.
module rpxx_settle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Holds at zero rather than wrapping so an idle timer stays quiet.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= value;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rpxx_offset_sequencer.sv
// Per-drive OFFSET / return-to-centerline sequencer: settle timing, attention,
// offset-mode status and RPOF write gating.
module rpxx_offset_sequencer
  import rpxx_offset_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 100,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       rpGO,
  input  logic [4:0] rpFUN,
  input  logic       rpofWRITEreq,
  output logic       rpofWRITE,
  output logic       ofsBUSY,
  output logic       ofsATA,
  output logic       ofsOM,
  output logic       ofsRMR
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  ofs_state_t state_q, state_d;
  logic       kill;
  logic       go_valid;
  logic       busy;
  logic       load;
  logic       timer_zero;
  logic       is_rtc_q;
  logic       om_q;
  logic       rmr_q;

  assign kill     = rst | clr;
  assign go_valid = rpGO & is_pos_fun(rpFUN);
  assign busy     = (state_q != IDLE);

  rpxx_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (kill),
    .load  (load),
    .value (LOAD_VAL),
    .zero  (timer_zero)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_valid) begin
          state_d = SETTLE;
          load    = 1'b1;
        end
      end
      SETTLE:  if (timer_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q  <= IDLE;
      is_rtc_q <= 1'b0;
      om_q     <= 1'b0;
      rmr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load)
        is_rtc_q <= (rpFUN == FUN_RTC);
      if (state_q == DONE)
        om_q <= ~is_rtc_q;
      // Refused command and refused write in one cycle merge into one pulse.
      rmr_q <= busy & (go_valid | rpofWRITEreq);
    end
  end

  assign rpofWRITE = rpofWRITEreq & ~busy;
  assign ofsBUSY   = busy;
  assign ofsATA    = (state_q == DONE);
  assign ofsOM     = om_q;
  assign ofsRMR    = rmr_q;

endmodule

// File: tb/tb_rpxx_offset_sequencer.sv
// Directed plus randomized bench for rpxx_offset_sequencer against a
// remaining-busy-cycles reference model.
module tb_rpxx_offset_sequencer;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst, clr, rpGO, rpofWRITEreq;
  logic [4:0] rpFUN;
  logic       rpofWRITE, ofsBUSY, ofsATA, ofsOM, ofsRMR;

  int tests = 0;
  int fails = 0;
  int ata_cnt = 0;

  // Reference model: cycles of busy remaining after the current edge.
  int m_rem = 0;
  bit m_rtc = 1'b0;
  bit m_om  = 1'b0;
  bit m_rmr = 1'b0;

  always #5 clk = ~clk;

  rpxx_offset_sequencer #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .rpGO         (rpGO),
    .rpFUN        (rpFUN),
    .rpofWRITEreq (rpofWRITEreq),
    .rpofWRITE    (rpofWRITE),
    .ofsBUSY      (ofsBUSY),
    .ofsATA       (ofsATA),
    .ofsOM        (ofsOM),
    .ofsRMR       (ofsRMR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit g, input logic [4:0] f, input bit w);
    bit gv;
    bit was_busy;
    rst = r; clr = c; rpGO = g; rpFUN = f; rpofWRITEreq = w;
    #1;
    chk("rpofWRITE", {31'd0, rpofWRITE}, {31'd0, w && (m_rem == 0)});
    @(posedge clk);
    gv = g && (f == 5'o06 || f == 5'o07);
    if (r || c) begin
      m_rem = 0; m_om = 1'b0; m_rmr = 1'b0;
    end else begin
      was_busy = (m_rem > 0);
      m_rmr = was_busy && (gv || w);
      if (was_busy) begin
        m_rem--;
        if (m_rem == 0) m_om = !m_rtc;
      end else if (gv) begin
        m_rem = S + 1;
        m_rtc = (f == 5'o07);
      end
    end
    #1;
    chk("ofsBUSY", {31'd0, ofsBUSY}, {31'd0, m_rem > 0});
    chk("ofsATA",  {31'd0, ofsATA},  {31'd0, m_rem == 1});
    chk("ofsOM",   {31'd0, ofsOM},   {31'd0, m_om});
    chk("ofsRMR",  {31'd0, ofsRMR},  {31'd0, m_rmr});
    if (ofsATA === 1'b1) ata_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 5'o00, 0);
  endtask

  initial begin
    int busy_cnt;
    logic [4:0] f;

    // 1. reset then idle
    cycle(1, 0, 0, 5'o00, 0);
    cycle(1, 0, 0, 5'o00, 0);
    idle(5);
    chk("reset_om", {31'd0, ofsOM}, 32'd0);

    // 2. OFFSET: busy 5 cycles, single ATA, OM set afterwards
    ata_cnt = 0; busy_cnt = 0;
    cycle(0, 0, 1, 5'o06, 0);
    if (ofsBUSY === 1'b1) busy_cnt++;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 5'o00, 0);
      if (ofsBUSY === 1'b1) busy_cnt++;
    end
    chk("offset_busy_len", busy_cnt, S + 1);
    chk("offset_ata_cnt", ata_cnt, 1);
    chk("offset_om", {31'd0, ofsOM}, 32'd1);

    // 3. RTC from OM=1
    ata_cnt = 0;
    cycle(0, 0, 1, 5'o07, 0);
    idle(6);
    chk("rtc_ata_cnt", ata_cnt, 1);
    chk("rtc_om", {31'd0, ofsOM}, 32'd0);

    // 4. write during SETTLE refused, write in IDLE passes
    cycle(0, 0, 1, 5'o06, 0);
    cycle(0, 0, 0, 5'o00, 1);
    idle(6);
    cycle(0, 0, 0, 5'o00, 1);
    // GO and write together in IDLE
    cycle(0, 0, 1, 5'o07, 1);
    idle(6);

    // 5. second OFFSET while busy, also combined with a write
    ata_cnt = 0;
    cycle(0, 0, 1, 5'o06, 0);
    cycle(0, 0, 1, 5'o06, 0);
    cycle(0, 0, 1, 5'o07, 1);
    idle(6);
    chk("double_go_ata_cnt", ata_cnt, 1);

    // 6. clr two cycles into SETTLE with OM=1, then an ignored function
    chk("pre_clr_om", {31'd0, ofsOM}, 32'd1);
    ata_cnt = 0;
    cycle(0, 0, 1, 5'o06, 0);
    idle(2);
    cycle(0, 1, 0, 5'o00, 0);
    chk("clr_busy", {31'd0, ofsBUSY}, 32'd0);
    chk("clr_om", {31'd0, ofsOM}, 32'd0);
    idle(8);
    chk("clr_no_ata", ata_cnt, 0);
    cycle(0, 0, 1, 5'o01, 0);
    chk("ignored_fun_busy", {31'd0, ofsBUSY}, 32'd0);
    idle(3);
    // clr beats a same-cycle GO
    cycle(0, 1, 1, 5'o06, 1);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(3, 0))
        0:       f = 5'o06;
        1:       f = 5'o07;
        2:       f = 5'o01;
        default: f = 5'($urandom_range(31, 0));
      endcase
      cycle(0, ($urandom_range(59, 0) == 0), ($urandom_range(3, 0) == 0), f,
            ($urandom_range(4, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
